// File: rtl/ps2_encode_if.sv
// ASCII-in / scan-code-out handshake bundle for the PS/2 encoder.
// master = ASCII producer (and scan-code consumer), slave = encoder.
interface ps2_encode_if;
  logic       asciiValid;
  logic [7:0] ascii;
  logic       asciiReady;
  logic       scanDone;
  logic [7:0] scanCode;
  logic       busy;
  logic       unsupported;

  modport master (
    output asciiValid, ascii,
    input  asciiReady, scanDone, scanCode, busy, unsupported
  );

  modport slave (
    input  asciiValid, ascii,
    output asciiReady, scanDone, scanCode, busy, unsupported
  );
endinterface

// File: rtl/ps2_encode.sv
// ASCII-to-PS/2 set-2 scan-code encoder. Emits make/break byte sequences
// on a scanDone/scanCode strobe so the keyboard decode path can be driven
// for emulation, loopback and decoder self-test. Shifted characters are
// wrapped in left-shift make/break; caps lock is never used.
module ps2_encode #(
  parameter int HOLD_CYCLES = 4,  // cycles scanDone high per byte (1..65535)
  parameter int GAP_CYCLES  = 4   // cycles scanDone low between bytes (1..65535)
) (
  input  logic         clk,
  input  logic         reset,     // async, active low
  ps2_encode_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_BREAK  = 8'hF0;

  logic [1:0]  r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_key;
  logic        r_shift;
  logic [7:0]  r_code;
  logic        r_unsup;

  logic [7:0]  w_key;
  logic        w_shift;
  logic        w_valid;
  logic        w_accept;
  logic [2:0]  w_last_idx;
  logic [2:0]  w_next_idx;

  // Set-2 make code for letter position 1..26 (a/A = 1). Upper and lower
  // case share the code; case is carried by the shift wrap.
  function automatic logic [7:0] letter_code(input logic [4:0] pos);
    logic [7:0] c;
    case (pos)
      5'd1:    c = 8'h1C;  // a
      5'd2:    c = 8'h32;  // b
      5'd3:    c = 8'h21;  // c
      5'd4:    c = 8'h23;  // d
      5'd5:    c = 8'h24;  // e
      5'd6:    c = 8'h2B;  // f
      5'd7:    c = 8'h34;  // g
      5'd8:    c = 8'h33;  // h
      5'd9:    c = 8'h43;  // i
      5'd10:   c = 8'h3B;  // j
      5'd11:   c = 8'h42;  // k
      5'd12:   c = 8'h4B;  // l
      5'd13:   c = 8'h3A;  // m
      5'd14:   c = 8'h31;  // n
      5'd15:   c = 8'h44;  // o
      5'd16:   c = 8'h4D;  // p
      5'd17:   c = 8'h15;  // q
      5'd18:   c = 8'h2D;  // r
      5'd19:   c = 8'h1B;  // s
      5'd20:   c = 8'h2C;  // t
      5'd21:   c = 8'h3C;  // u
      5'd22:   c = 8'h2A;  // v
      5'd23:   c = 8'h1D;  // w
      5'd24:   c = 8'h22;  // x
      5'd25:   c = 8'h35;  // y
      5'd26:   c = 8'h1A;  // z
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Byte idx of the emitted sequence.
  //   plain:   key F0 key
  //   shifted: 12 key F0 key F0 12
  function automatic logic [7:0] seq_byte(input logic [2:0] idx,
                                          input logic [7:0] key,
                                          input logic       shift);
    logic [7:0] b;
    if (!shift) begin
      case (idx)
        3'd1:    b = SC_BREAK;
        default: b = key;
      endcase
    end else begin
      case (idx)
        3'd0:    b = SC_LSHIFT;
        3'd1:    b = key;
        3'd2:    b = SC_BREAK;
        3'd3:    b = key;
        3'd4:    b = SC_BREAK;
        default: b = SC_LSHIFT;
      endcase
    end
    return b;
  endfunction

  // ASCII lookup: key code, shift requirement and whether the byte maps at all.
  always_comb begin
    w_key   = 8'h00;
    w_shift = 1'b0;
    w_valid = 1'b1;
    if (bus.ascii[7]) begin
      w_valid = 1'b0;
    end else if (bus.ascii >= 8'h61 && bus.ascii <= 8'h7A) begin
      w_key = letter_code(bus.ascii[4:0]);
    end else if (bus.ascii >= 8'h41 && bus.ascii <= 8'h5A) begin
      w_key   = letter_code(bus.ascii[4:0]);
      w_shift = 1'b1;
    end else begin
      case (bus.ascii)
        // digits
        8'h30: w_key = 8'h45;
        8'h31: w_key = 8'h16;
        8'h32: w_key = 8'h1E;
        8'h33: w_key = 8'h26;
        8'h34: w_key = 8'h25;
        8'h35: w_key = 8'h2E;
        8'h36: w_key = 8'h36;
        8'h37: w_key = 8'h3D;
        8'h38: w_key = 8'h3E;
        8'h39: w_key = 8'h46;
        // shifted digit row ) ! @ # $ % ^ & * (
        8'h29: begin w_key = 8'h45; w_shift = 1'b1; end
        8'h21: begin w_key = 8'h16; w_shift = 1'b1; end
        8'h40: begin w_key = 8'h1E; w_shift = 1'b1; end
        8'h23: begin w_key = 8'h26; w_shift = 1'b1; end
        8'h24: begin w_key = 8'h25; w_shift = 1'b1; end
        8'h25: begin w_key = 8'h2E; w_shift = 1'b1; end
        8'h5E: begin w_key = 8'h36; w_shift = 1'b1; end
        8'h26: begin w_key = 8'h3D; w_shift = 1'b1; end
        8'h2A: begin w_key = 8'h3E; w_shift = 1'b1; end
        8'h28: begin w_key = 8'h46; w_shift = 1'b1; end
        // punctuation pairs: unshifted / shifted
        8'h60: w_key = 8'h0E;
        8'h7E: begin w_key = 8'h0E; w_shift = 1'b1; end
        8'h2D: w_key = 8'h4E;
        8'h5F: begin w_key = 8'h4E; w_shift = 1'b1; end
        8'h3D: w_key = 8'h55;
        8'h2B: begin w_key = 8'h55; w_shift = 1'b1; end
        8'h5C: w_key = 8'h5D;
        8'h7C: begin w_key = 8'h5D; w_shift = 1'b1; end
        8'h5B: w_key = 8'h54;
        8'h7B: begin w_key = 8'h54; w_shift = 1'b1; end
        8'h5D: w_key = 8'h5B;
        8'h7D: begin w_key = 8'h5B; w_shift = 1'b1; end
        8'h3B: w_key = 8'h4C;
        8'h3A: begin w_key = 8'h4C; w_shift = 1'b1; end
        8'h27: w_key = 8'h52;
        8'h22: begin w_key = 8'h52; w_shift = 1'b1; end
        8'h2C: w_key = 8'h41;
        8'h3C: begin w_key = 8'h41; w_shift = 1'b1; end
        8'h2E: w_key = 8'h49;
        8'h3E: begin w_key = 8'h49; w_shift = 1'b1; end
        8'h2F: w_key = 8'h4A;
        8'h3F: begin w_key = 8'h4A; w_shift = 1'b1; end
        // whitespace / control keys
        8'h20: w_key = 8'h29;
        8'h08: w_key = 8'h66;
        8'h09: w_key = 8'h0D;
        8'h0A: w_key = 8'h5A;
        8'h1B: w_key = 8'h76;
        default: w_valid = 1'b0;
      endcase
    end
  end

  assign w_accept   = bus.asciiValid && (r_state == S_IDLE);
  assign w_last_idx = r_shift ? 3'd5 : 3'd2;
  assign w_next_idx = 3'(r_idx + 3'd1);

  // Sequencer: IDLE -> HIGH (hold) -> LOW (gap) -> next byte or IDLE.
  // Inputs are only sampled in IDLE; the latched key drives the whole run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_idx   <= 3'd0;
      r_key   <= 8'h00;
      r_shift <= 1'b0;
      r_code  <= 8'h00;
      r_unsup <= 1'b0;
    end else begin
      r_unsup <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_valid) begin
              r_key   <= w_key;
              r_shift <= w_shift;
              r_idx   <= 3'd0;
              r_cnt   <= 16'd0;
              r_code  <= seq_byte(3'd0, w_key, w_shift);
              r_state <= S_HIGH;
            end else begin
              // unmapped byte is consumed but nothing is sent
              r_unsup <= 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (r_cnt == HOLD_LAST) begin
            r_cnt   <= 16'd0;
            r_state <= S_LOW;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_LOW: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt <= 16'd0;
            if (r_idx == w_last_idx) begin
              r_state <= S_IDLE;
            end else begin
              // scanCode only moves on HIGH entry so it is stable during HIGH
              r_idx   <= w_next_idx;
              r_code  <= seq_byte(w_next_idx, r_key, r_shift);
              r_state <= S_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.asciiReady  = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.scanDone    = (r_state == S_HIGH);
  assign bus.scanCode    = r_code;
  assign bus.unsupported = r_unsup;

endmodule

// File: tb/tb_ps2_encode.sv
// Directed bench for ps2_encode: one instance with HOLD=GAP=4, one with
// HOLD=GAP=1. Expected scan-code sequences are written out by hand.
module tb_ps2_encode;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ps2_encode_if b4 ();
  ps2_encode_if b1 ();

  ps2_encode #(.HOLD_CYCLES(4), .GAP_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));
  ps2_encode #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

  // sel=0 drives/observes dut4, sel=1 dut1
  bit         sel = 1'b0;
  logic       vld = 1'b0;
  logic [7:0] asc = 8'h00;

  assign b4.asciiValid = vld & ~sel;
  assign b1.asciiValid = vld & sel;
  assign b4.ascii      = asc;
  assign b1.ascii      = asc;

  wire       m_ready = sel ? b1.asciiReady  : b4.asciiReady;
  wire       m_done  = sel ? b1.scanDone    : b4.scanDone;
  wire [7:0] m_code  = sel ? b1.scanCode    : b4.scanCode;
  wire       m_busy  = sel ? b1.busy        : b4.busy;
  wire       m_unsup = sel ? b1.unsupported : b4.unsupported;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the selected DUT idle. Presents c, then checks
  // every cycle of the sequence and the idle state afterwards.
  task automatic send(input logic [7:0] c, input logic [7:0] exp [6], input int n,
                      input bit scramble);
    int hold = sel ? 1 : 4;
    int gap  = sel ? 1 : 4;
    asc = c;
    vld = 1'b1;
    chk("ready_before", m_ready, 1'b1);
    @(posedge clk);
    for (int b = 0; b < n; b++) begin
      for (int p = 0; p < hold + gap; p++) begin
        @(negedge clk);
        if (scramble) begin
          asc = 8'($urandom);
          vld = 1'($urandom);
        end else begin
          vld = 1'b0;
        end
        chk($sformatf("done[%0d.%0d]", b, p), m_done, (p < hold) ? 8'd1 : 8'd0);
        chk($sformatf("code[%0d.%0d]", b, p), m_code, exp[b]);
        chk($sformatf("busy[%0d.%0d]", b, p), m_busy, 1'b1);
        chk($sformatf("ready[%0d.%0d]", b, p), m_ready, 1'b0);
      end
    end
    @(negedge clk);
    vld = 1'b0;
    chk("idle_ready", m_ready, 1'b1);
    chk("idle_busy", m_busy, 1'b0);
    chk("idle_done", m_done, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, m_ready, 1'b1);
    chk({tag, "_done"},  m_done,  1'b0);
    chk({tag, "_code"},  m_code,  8'h00);
    chk({tag, "_busy"},  m_busy,  1'b0);
    chk({tag, "_unsup"}, m_unsup, 1'b0);
  endtask

  initial begin
    // reset state of both instances
    repeat (2) @(negedge clk);
    sel = 1'b0; chk_reset_vals("rst4");
    sel = 1'b1; chk_reset_vals("rst1");
    sel = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // 'a' -> 1C F0 1C
    send(8'h61, '{8'h1C, 8'hF0, 8'h1C, 8'h00, 8'h00, 8'h00}, 3, 1'b0);
    // 'A' -> 12 1C F0 1C F0 12
    send(8'h41, '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12}, 6, 1'b0);
    // '@' then LF back-to-back, second accepted on first ready cycle
    send(8'h40, '{8'h12, 8'h1E, 8'hF0, 8'h1E, 8'hF0, 8'h12}, 6, 1'b0);
    send(8'h0A, '{8'h5A, 8'hF0, 8'h5A, 8'h00, 8'h00, 8'h00}, 3, 1'b0);

    // unsupported bytes: DEL and a bit-7 byte, back to back
    asc = 8'h7F; vld = 1'b1;
    @(negedge clk);
    chk("unsup_7F", m_unsup, 1'b1);
    chk("unsup_7F_ready", m_ready, 1'b1);
    chk("unsup_7F_done", m_done, 1'b0);
    asc = 8'hC1;
    @(negedge clk);
    vld = 1'b0;
    chk("unsup_C1", m_unsup, 1'b1);
    chk("unsup_C1_ready", m_ready, 1'b1);
    chk("unsup_C1_done", m_done, 1'b0);
    @(negedge clk);
    chk("unsup_clear", m_unsup, 1'b0);
    chk("unsup_clear_done", m_done, 1'b0);
    chk("unsup_clear_busy", m_busy, 1'b0);

    // reset during second HIGH phase of 'A'
    asc = 8'h41; vld = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);  // cycles 9,10 are byte 1 high
    vld = 1'b0;
    chk("mid_done", m_done, 1'b1);
    chk("mid_code", m_code, 8'h1C);
    reset = 1'b0;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    chk_reset_vals("held");
    reset = 1'b1;
    @(negedge clk);
    // 'b' after reset -> 32 F0 32
    send(8'h62, '{8'h32, 8'hF0, 8'h32, 8'h00, 8'h00, 8'h00}, 3, 1'b0);

    // inputs toggled while busy must not disturb the sequence
    send(8'h2D, '{8'h4E, 8'hF0, 8'h4E, 8'h00, 8'h00, 8'h00}, 3, 1'b1);

    // single-cycle strobes
    sel = 1'b1;
    @(negedge clk);
    send(8'h7A, '{8'h1A, 8'hF0, 8'h1A, 8'h00, 8'h00, 8'h00}, 3, 1'b1);
    send(8'h3F, '{8'h12, 8'h4A, 8'hF0, 8'h4A, 8'hF0, 8'h12}, 6, 1'b1);
    send(8'h20, '{8'h29, 8'hF0, 8'h29, 8'h00, 8'h00, 8'h00}, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
